// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DROP
    } fetch_state_e;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FETCH_NOP      = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] PC_STEP        = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise a bubble is inserted.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP = FETCH_NOP
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = NOP;
        pc4_d   = '0;
        valid_d = 1'b0;
        if (flush_i) begin
            instr_d = NOP;
        end else if (hold_i) begin
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end else if (load_i) begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            instr_q <= NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding fetch handshake, skid buffer and IF/ID register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter logic [31:0] NOP_INSTR = FETCH_NOP
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic [5:0]  Opcode,
    output logic [5:0]  Funct
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_pc4_q, hold_pc4_d;

    logic [31:0]  pc_plus4;
    logic [31:0]  redir_pc;
    logic         new_instr;
    logic [31:0]  src_instr;
    logic [31:0]  src_pc4;

    assign pc_plus4 = pc_q + PC_STEP;
    assign redir_pc = word_align(RedirectPC);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        IMemReq      = 1'b0;
        new_instr    = 1'b0;
        src_instr    = IMemData;
        src_pc4      = pc_plus4;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (Redirect) pc_d = redir_pc;
            end
            S_REQ: begin
                IMemReq = 1'b1;
                if (IMemAck) begin
                    if (Redirect) begin
                        pc_d = redir_pc;
                    end else begin
                        new_instr = 1'b1;
                        pc_d      = pc_plus4;
                        // Decode is stalled: park the word instead of refetching it later.
                        if (Stall) begin
                            hold_instr_d = IMemData;
                            hold_pc4_d   = pc_plus4;
                            state_d      = S_HOLD;
                        end
                    end
                end else if (Redirect) begin
                    target_d = redir_pc;
                    state_d  = S_DROP;
                end
            end
            S_HOLD: begin
                src_instr = hold_instr_q;
                src_pc4   = hold_pc4_q;
                if (Redirect) begin
                    pc_d         = redir_pc;
                    hold_instr_d = NOP_INSTR;
                    hold_pc4_d   = '0;
                    state_d      = S_REQ;
                end else if (!Stall) begin
                    new_instr = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_DROP: begin
                // Keep presenting the old address until the stale fetch retires.
                IMemReq = 1'b1;
                if (Redirect) target_d = redir_pc;
                if (IMemAck) begin
                    pc_d    = Redirect ? redir_pc : target_q;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q      <= S_IDLE;
            pc_q         <= word_align(RESET_PC);
            target_q     <= '0;
            hold_instr_q <= NOP_INSTR;
            hold_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
        end
    end

    assign IMemAddr = pc_q;

    if_id_reg #(
        .NOP(NOP_INSTR)
    ) u_if_id (
        .clk_i  (Clk),
        .rst_ni (Rst),
        .flush_i(Redirect),
        .hold_i (Stall),
        .load_i (new_instr),
        .instr_i(src_instr),
        .pc4_i  (src_pc4),
        .instr_o(IF_ID_Instr),
        .pc4_o  (IF_ID_PCPlus4),
        .valid_o(IF_ID_Valid)
    );

    assign Opcode = IF_ID_Instr[31:26];
    assign Funct  = IF_ID_Instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-programmable memory model plus a scoreboard of expected IF/ID loads.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic        mem_en;
    int          lat;
    int          cnt;
    logic        mon_upd;

    fetch_stage dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemAck      (IMemAck),
        .IMemData     (IMemData),
        .IF_ID_Instr  (IF_ID_Instr),
        .IF_ID_PCPlus4(IF_ID_PCPlus4),
        .IF_ID_Valid  (IF_ID_Valid),
        .Opcode       (Opcode),
        .Funct        (Funct)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C08_0004;
        return {4'hE, a[27:0]};
    endfunction

    // Memory acks once the request has waited lat cycles; lat=0 is zero-wait.
    assign IMemAck  = IMemReq && mem_en && (cnt >= lat);
    assign IMemData = mem_word(IMemAddr);

    always @(posedge Clk) begin
        if (!Rst || !mem_en || IMemAck) cnt <= 0;
        else if (IMemReq)               cnt <= cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] addr);
        exp_t e;
        e.instr = mem_word(addr);
        e.pc4   = addr + 32'd4;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},    {31'b0, IMemReq}, 32'd0);
        chk({tag, "_addr"},   IMemAddr, 32'h0);
        chk({tag, "_instr"},  IF_ID_Instr, 32'h0);
        chk({tag, "_pc4"},    IF_ID_PCPlus4, 32'h0);
        chk({tag, "_valid"},  {31'b0, IF_ID_Valid}, 32'd0);
        chk({tag, "_opcode"}, {26'b0, Opcode}, 32'd0);
        chk({tag, "_funct"},  {26'b0, Funct}, 32'd0);
    endtask

    // Scoreboard: every edge that may update IF/ID and leaves a valid word must match the next expectation.
    always @(posedge Clk) begin
        mon_upd = Rst && (!Stall || Redirect);
        #2;
        if (mon_upd && IF_ID_Valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_valid", {31'b0, IF_ID_Valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_instr", IF_ID_Instr, e.instr);
                chk("sb_pc4", IF_ID_PCPlus4, e.pc4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Rst = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
        mem_en = 1'b1; lat = 0;
        tick; tick;
        chk_reset("rst");

        // Zero-wait stream from address 0
        push(32'h0); push(32'h4); push(32'h8);
        Rst = 1'b1;
        tick;
        chk("first_req", {31'b0, IMemReq}, 32'd1);
        chk("first_addr", IMemAddr, 32'h0);
        tick;
        chk("opcode0", {26'b0, Opcode}, 32'h23);
        chk("funct0", {26'b0, Funct}, 32'h04);
        chk("addr_4", IMemAddr, 32'h4);
        tick;
        chk("pc4_8", IF_ID_PCPlus4, 32'h8);
        chk("addr_8", IMemAddr, 32'h8);
        tick;
        chk("pc4_12", IF_ID_PCPlus4, 32'hC);
        mem_en = 1'b0;
        tick;
        chk("idle_bubble", {31'b0, IF_ID_Valid}, 32'd0);

        // One fetch at 0xC, then stall while 0x10 is acked
        push(32'hC); mem_en = 1'b1;
        tick;
        Stall = 1'b1;
        tick;
        chk("hold_req", {31'b0, IMemReq}, 32'd0);
        chk("hold_pc4", IF_ID_PCPlus4, 32'h10);
        mem_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("stall_instr", IF_ID_Instr, mem_word(32'hC));
            chk("stall_valid", {31'b0, IF_ID_Valid}, 32'd1);
        end
        Stall = 1'b0; push(32'h10);
        tick;
        chk("release_pc4", IF_ID_PCPlus4, 32'h14);
        chk("after_hold_addr", IMemAddr, 32'h14);
        chk("after_hold_req", {31'b0, IMemReq}, 32'd1);

        // Park 0x14 in Hold, then Redirect+Stall with nothing outstanding
        Stall = 1'b1; mem_en = 1'b1;
        tick;
        chk("hold2_valid", {31'b0, IF_ID_Valid}, 32'd1);
        Redirect = 1'b1; RedirectPC = 32'h40; mem_en = 1'b0;
        tick;
        chk("redir_valid", {31'b0, IF_ID_Valid}, 32'd0);
        chk("redir_addr", IMemAddr, 32'h40);
        chk("redir_req", {31'b0, IMemReq}, 32'd1);
        Redirect = 1'b0; Stall = 1'b0; mem_en = 1'b1; push(32'h40);
        tick;
        chk("target_pc4", IF_ID_PCPlus4, 32'h44);

        // Zero-wait ack with redirect drops data
        Redirect = 1'b1; RedirectPC = 32'h20;
        tick;
        chk("ackredir_valid", {31'b0, IF_ID_Valid}, 32'd0);
        chk("ackredir_addr", IMemAddr, 32'h20);

        // 3-cycle memory: redirect to 0x80 while 0x20 is pending
        RedirectPC = 32'h80; lat = 3;
        tick;
        Redirect = 1'b0;
        chk("drop_addr0", IMemAddr, 32'h20);
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("drop_addr", IMemAddr, 32'h20);
            chk("drop_req", {31'b0, IMemReq}, 32'd1);
        end
        tick;
        chk("drop_valid", {31'b0, IF_ID_Valid}, 32'd0);
        chk("drop_next_addr", IMemAddr, 32'h80);

        // PC wrap at the top of the address space
        lat = 0; Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
        tick;
        chk("wrap_addr", IMemAddr, 32'hFFFF_FFFC);
        Redirect = 1'b0; push(32'hFFFF_FFFC);
        tick;
        chk("wrap_next_addr", IMemAddr, 32'h0);
        chk("wrap_pc4", IF_ID_PCPlus4, 32'h0);

        // Unaligned redirect target is word-aligned
        Redirect = 1'b1; RedirectPC = 32'h43;
        tick;
        chk("align_addr", IMemAddr, 32'h40);
        Redirect = 1'b0; lat = 3;
        tick;

        // Mid-fetch reset with an ack present in the reset cycle
        Rst = 1'b0; lat = 0;
        tick;
        chk_reset("midrst");
        Rst = 1'b1; mem_en = 1'b0;
        tick;
        chk("rerun_req", {31'b0, IMemReq}, 32'd1);
        chk("rerun_addr", IMemAddr, 32'h0);
        tick;

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
